// File: rtl/sram_bus_ctrl.sv
// Bus responder that arbitrates the core's fetch and load/store ports onto one shared async SRAM.
// Define FETCH_BUF_EN to add a one-entry fetch buffer that lets a repeated fetch skip the SRAM.
module sram_bus_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rom_addr_i,
    input  logic              rom_ce_n_i,
    output logic [31:0]       rom_data_o,
    input  logic [31:0]       ram_addr_i,
    input  logic [31:0]       ram_data_i,
    input  logic              ram_we_n_i,
    input  logic [3:0]        ram_be_n_i,
    input  logic              ram_ce_n_i,
    input  logic              ram_oe_n_i,
    output logic [31:0]       ram_data_o,
    output logic              stall_from_bus,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_data_i,
    output logic [31:0]       sram_data_o,
    output logic              sram_data_oe,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o
);

    localparam int CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    typedef enum logic [2:0] {
        IDLE,
        DRD,
        IRD,
        WSETUP,
        WPULSE,
        WHOLD,
        REL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dDone_q, dDone_d;
    logic               iDone_q, iDone_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wrData_q, wrData_d;
    logic [3:0]         beN_q, beN_d;
    logic [31:0]        romData_q, romData_d;
    logic [31:0]        ramData_q, ramData_d;

    logic               dReq, iReq, dWrite, dPend, iPend, iHit, lastCycle;
    logic [ADDR_W-1:0]  romWord, ramWord;

    // Byte-offset and upper address bits never reach the word-addressed SRAM; a load is any non-write data request.
    logic               unusedBits;
    assign unusedBits = ^{ram_oe_n_i, rom_addr_i[1:0], rom_addr_i[31:ADDR_W+2],
                          ram_addr_i[1:0], ram_addr_i[31:ADDR_W+2]};

    assign romWord   = rom_addr_i[ADDR_W+1:2];
    assign ramWord   = ram_addr_i[ADDR_W+1:2];
    assign dReq      = !ram_ce_n_i;
    assign iReq      = !rom_ce_n_i;
    assign dWrite    = !ram_we_n_i;
    assign dPend     = dReq && !dDone_q;
    assign iPend     = iReq && !iDone_q;
    assign lastCycle = (cnt_q == '0);

`ifdef FETCH_BUF_EN
    logic [ADDR_W-1:0]  bufTag_q, bufTag_d;
    logic               bufValid_q, bufValid_d;

    assign iHit = bufValid_q && (bufTag_q == romWord);
`else
    assign iHit = 1'b0;
`endif

    // REL is the one cycle the core is released; reset also drops the hold immediately.
    assign stall_from_bus = rst && (state_q != REL) && (dPend || iPend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dDone_q    <= 1'b0;
            iDone_q    <= 1'b0;
            addr_q     <= '0;
            wrData_q   <= '0;
            beN_q      <= 4'hF;
            romData_q  <= '0;
            ramData_q  <= '0;
`ifdef FETCH_BUF_EN
            bufTag_q   <= '0;
            bufValid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dDone_q    <= dDone_d;
            iDone_q    <= iDone_d;
            addr_q     <= addr_d;
            wrData_q   <= wrData_d;
            beN_q      <= beN_d;
            romData_q  <= romData_d;
            ramData_q  <= ramData_d;
`ifdef FETCH_BUF_EN
            bufTag_q   <= bufTag_d;
            bufValid_q <= bufValid_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        dDone_d   = dDone_q;
        iDone_d   = iDone_q;
        addr_d    = addr_q;
        wrData_d  = wrData_q;
        beN_d     = beN_q;
        romData_d = romData_q;
        ramData_d = ramData_q;
`ifdef FETCH_BUF_EN
        bufTag_d   = bufTag_q;
        bufValid_d = bufValid_q;
`endif
        case (state_q)
            IDLE: begin
                // A buffered fetch completes here even when a data access goes first.
                if (iPend && iHit) begin
                    iDone_d = 1'b1;
                end
                if (dPend && dWrite) begin
                    state_d  = WSETUP;
                    addr_d   = ramWord;
                    wrData_d = ram_data_i;
                    beN_d    = ram_be_n_i;
                end else if (dPend) begin
                    state_d = DRD;
                    addr_d  = ramWord;
                end else if (iPend && !iHit) begin
                    state_d = IRD;
                    addr_d  = romWord;
                end else if (dReq || iReq) begin
                    state_d = REL;
                end
            end
            DRD: begin
                if (lastCycle) begin
                    ramData_d = sram_data_i;
                    dDone_d   = 1'b1;
                    if (iPend) begin
                        state_d = IRD;
                        addr_d  = romWord;
                    end else begin
                        state_d = REL;
                    end
                end
            end
            IRD: begin
                if (lastCycle) begin
                    romData_d = sram_data_i;
                    iDone_d   = 1'b1;
                    state_d   = REL;
`ifdef FETCH_BUF_EN
                    bufTag_d   = addr_q;
                    bufValid_d = 1'b1;
`endif
                end
            end
            WSETUP: begin
                state_d = WPULSE;
            end
            WPULSE: begin
                if (lastCycle) begin
                    state_d = WHOLD;
                end
            end
            WHOLD: begin
                dDone_d = 1'b1;
`ifdef FETCH_BUF_EN
                if (addr_q == bufTag_q) begin
                    bufValid_d = 1'b0;
                end
`endif
                if (iPend) begin
                    state_d = IRD;
                    addr_d  = romWord;
                end else begin
                    state_d = REL;
                end
            end
            REL: begin
                dDone_d = 1'b0;
                iDone_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The wait counter reloads with the remaining length on each state entry and saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                DRD, IRD: cnt_d = CNT_W'(RD_WAIT);
                WPULSE:   cnt_d = CNT_W'(WR_WAIT - 1);
                default:  cnt_d = '0;
            endcase
        end else if (!lastCycle) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        sram_ce_n_o  = 1'b1;
        sram_oe_n_o  = 1'b1;
        sram_we_n_o  = 1'b1;
        sram_be_n_o  = 4'hF;
        sram_data_oe = 1'b0;
        case (state_q)
            DRD, IRD: begin
                sram_ce_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
                sram_be_n_o = 4'h0;
            end
            WSETUP, WHOLD: begin
                sram_ce_n_o  = 1'b0;
                sram_be_n_o  = beN_q;
                sram_data_oe = 1'b1;
            end
            WPULSE: begin
                sram_ce_n_o  = 1'b0;
                sram_we_n_o  = 1'b0;
                sram_be_n_o  = beN_q;
                sram_data_oe = 1'b1;
            end
            default: begin
                sram_ce_n_o = 1'b1;
            end
        endcase
    end

    assign sram_addr_o = addr_q;
    assign sram_data_o = wrData_q;
    assign rom_data_o  = romData_q;
    assign ram_data_o  = ramData_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Scoreboard bench for sram_bus_ctrl: a randomized core issues fetch/load/store bundles, a
// memory-level reference model predicts the returned data and the number of stalled cycles.
module tb_sram_bus_ctrl;

    localparam int ADDR_W  = 20;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       rom_addr_i = '0;
    logic              rom_ce_n_i = 1'b1;
    logic [31:0]       rom_data_o;
    logic [31:0]       ram_addr_i = '0;
    logic [31:0]       ram_data_i = '0;
    logic              ram_we_n_i = 1'b1;
    logic [3:0]        ram_be_n_i = 4'hF;
    logic              ram_ce_n_i = 1'b1;
    logic              ram_oe_n_i = 1'b1;
    logic [31:0]       ram_data_o;
    logic              stall_from_bus;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [31:0]       sram_data_i = '0;
    logic [31:0]       sram_data_o;
    logic              sram_data_oe;
    logic              sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
    logic [3:0]        sram_be_n_o;

    always #5 clk = ~clk;

    sram_bus_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .rst(rst),
        .rom_addr_i(rom_addr_i), .rom_ce_n_i(rom_ce_n_i), .rom_data_o(rom_data_o),
        .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i), .ram_we_n_i(ram_we_n_i),
        .ram_be_n_i(ram_be_n_i), .ram_ce_n_i(ram_ce_n_i), .ram_oe_n_i(ram_oe_n_i),
        .ram_data_o(ram_data_o), .stall_from_bus(stall_from_bus),
        .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i), .sram_data_o(sram_data_o),
        .sram_data_oe(sram_data_oe), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
    );

    typedef struct {
        string       name;
        int          latency;
        bit          chkF;
        logic [31:0] fData;
        bit          chkD;
        logic [31:0] dData;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] sramMem[int];
    logic [31:0] refMem[int];
    int          ceLowCycles, dataOeCycles, weLowCycles, oeLowCycles;
    int          bothLowCycles = 0;
    int          lastCeAddr;
    logic [3:0]  beAtWe;
`ifdef FETCH_BUF_EN
    bit          bufValid = 0;
    int          bufTag = 0;
    logic [31:0] bufData = '0;
`endif

    function automatic logic [31:0] initWord(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] refRead(input int w);
        return refMem.exists(w) ? refMem[w] : initWord(w);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Asynchronous SRAM device: commits bytes while we_n is low, returns the addressed word while oe_n is low.
    initial forever begin
        @(negedge clk);
        if (!sram_ce_n_o && !sram_we_n_o) begin
            logic [31:0] w;
            w = sramMem.exists(int'(sram_addr_o)) ? sramMem[int'(sram_addr_o)] : initWord(int'(sram_addr_o));
            for (int b = 0; b < 4; b++)
                if (!sram_be_n_o[b]) w[8*b +: 8] = sram_data_o[8*b +: 8];
            sramMem[int'(sram_addr_o)] = w;
        end
        if (!sram_ce_n_o && !sram_oe_n_o)
            sram_data_i = sramMem.exists(int'(sram_addr_o)) ? sramMem[int'(sram_addr_o)] : initWord(int'(sram_addr_o));
        else
            sram_data_i = 32'hBAD0_BAD0;
    end

    initial forever begin
        @(negedge clk);
        if (!sram_ce_n_o) begin
            ceLowCycles++;
            lastCeAddr = int'(sram_addr_o);
        end
        if (sram_data_oe) dataOeCycles++;
        if (!sram_we_n_o) begin
            weLowCycles++;
            beAtWe = sram_be_n_o;
        end
        if (!sram_oe_n_o) oeLowCycles++;
        if (!sram_oe_n_o && !sram_we_n_o) bothLowCycles++;
    end

    // Monitor: counts stalled cycles of the active request and scores it when the core is released.
    initial begin
        int   stallCnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stallCnt = 0;
            end else if (!rom_ce_n_i || !ram_ce_n_i) begin
                if (stall_from_bus) begin
                    stallCnt++;
                end else begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_release", 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({e.name, "_stall_cycles"}, 32'(stallCnt), 32'(e.latency));
                        if (e.chkF) checkOutput({e.name, "_rom_data_o"}, rom_data_o, e.fData);
                        if (e.chkD) checkOutput({e.name, "_ram_data_o"}, ram_data_o, e.dData);
                    end
                    stallCnt = 0;
                end
            end
        end
    end

    task automatic clearBus();
        ceLowCycles  = 0;
        dataOeCycles = 0;
        weLowCycles  = 0;
        oeLowCycles  = 0;
        lastCeAddr   = -1;
        beAtWe       = 4'hF;
    endtask

    // Reference model: memory semantics plus the documented per-phase cycle costs.
    task automatic predict(input string name, input bit doFetch, input bit doData, input bit isStore,
                           input logic [31:0] fAddr, input logic [31:0] dAddr,
                           input logic [31:0] wData, input logic [3:0] beN, output exp_t e);
        int          fw, dw;
        bit          hit;
        logic [31:0] w;
        fw = int'(fAddr[ADDR_W+1:2]);
        dw = int'(dAddr[ADDR_W+1:2]);
        e.name = name; e.latency = 1; e.chkF = 0; e.chkD = 0; e.fData = '0; e.dData = '0;
`ifdef FETCH_BUF_EN
        hit = doFetch && bufValid && (bufTag == fw);
`else
        hit = 0;
`endif
        if (doData && isStore) begin
            w = refRead(dw);
            for (int b = 0; b < 4; b++)
                if (!beN[b]) w[8*b +: 8] = wData[8*b +: 8];
            refMem[dw] = w;
            e.latency += WR_WAIT + 2;
`ifdef FETCH_BUF_EN
            if (bufValid && bufTag == dw) bufValid = 0;
`endif
        end else if (doData) begin
            e.chkD = 1;
            e.dData = refRead(dw);
            e.latency += RD_WAIT + 1;
        end
        if (doFetch) begin
            e.chkF = 1;
`ifdef FETCH_BUF_EN
            if (hit) begin
                e.fData = bufData;
            end else begin
                e.fData = refRead(fw);
                e.latency += RD_WAIT + 1;
                bufValid = 1; bufTag = fw; bufData = e.fData;
            end
`else
            if (!hit) begin
                e.fData = refRead(fw);
                e.latency += RD_WAIT + 1;
            end
`endif
        end
    endtask

    // Issues one bundle at posedge+1, holds it until the bus releases the core, then drops it.
    task automatic applyStimulus(input string name, input bit doFetch, input bit doData, input bit isStore,
                                 input logic [31:0] fAddr, input logic [31:0] dAddr,
                                 input logic [31:0] wData, input logic [3:0] beN);
        exp_t e;
        bit   done;
        predict(name, doFetch, doData, isStore, fAddr, dAddr, wData, beN, e);
        expQ.push_back(e);
        rom_addr_i = fAddr;
        rom_ce_n_i = !doFetch;
        ram_addr_i = dAddr;
        ram_data_i = wData;
        ram_be_n_i = beN;
        ram_ce_n_i = !doData;
        ram_we_n_i = !(doData && isStore);
        ram_oe_n_i = (doData && isStore) ? 1'($urandom_range(0, 1)) : !doData;
        done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (!stall_from_bus) done = 1;
        end
        if (!done) begin
            checkOutput({name, "_release_timeout"}, 32'd1, 32'd0);
            expQ.delete();
        end
        @(posedge clk);
        #1;
        rom_ce_n_i = 1'b1;
        ram_ce_n_i = 1'b1;
        ram_we_n_i = 1'b1;
        ram_oe_n_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] aborted");
    end

    initial begin
        int nWe;
        sramMem[4] = 32'h2402_0005;     refMem[4] = 32'h2402_0005;
        sramMem['h40] = 32'hDEAD_BEEF;  refMem['h40] = 32'hDEAD_BEEF;

        // Requests held high during reset must not raise the stall or move the strobes.
        rom_ce_n_i = 1'b0; ram_ce_n_i = 1'b0; ram_we_n_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall", 32'(stall_from_bus), 32'd0);
        checkOutput("rst_rom_data_o", rom_data_o, 32'd0);
        checkOutput("rst_ram_data_o", ram_data_o, 32'd0);
        checkOutput("rst_ce_n", 32'(sram_ce_n_o), 32'd1);
        checkOutput("rst_oe_n", 32'(sram_oe_n_o), 32'd1);
        checkOutput("rst_we_n", 32'(sram_we_n_o), 32'd1);
        checkOutput("rst_be_n", 32'(sram_be_n_o), 32'hF);
        checkOutput("rst_data_oe", 32'(sram_data_oe), 32'd0);
        checkOutput("rst_addr", 32'(sram_addr_o), 32'd0);
        rom_ce_n_i = 1'b1; ram_ce_n_i = 1'b1; ram_we_n_i = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        clearBus();
        applyStimulus("t1_fetch", 1, 0, 0, 32'h8000_0010, '0, '0, 4'hF);
        checkOutput("t1_ce_cycles", 32'(ceLowCycles), 32'd2);
        checkOutput("t1_sram_addr", 32'(lastCeAddr), 32'd4);

        clearBus();
        applyStimulus("t2_fetch_load", 1, 1, 0, 32'h8000_0020, 32'h8000_0100, '0, 4'hF);
        checkOutput("t2_ce_cycles", 32'(ceLowCycles), 32'd4);
        checkOutput("t2_last_addr", 32'(lastCeAddr), 32'd8);

        clearBus();
        applyStimulus("t3_store", 0, 1, 1, '0, 32'h8000_0200, 32'h1234_5678, 4'b1100);
        checkOutput("t3_data_oe_cycles", 32'(dataOeCycles), 32'd4);
        checkOutput("t3_we_low_cycles", 32'(weLowCycles), 32'd2);
        checkOutput("t3_be_n", 32'(beAtWe), 32'b1100);
        checkOutput("t3_oe_low_cycles", 32'(oeLowCycles), 32'd0);
        applyStimulus("t3_readback", 0, 1, 0, '0, 32'h8000_0200, '0, 4'hF);

        // Reset lands in the middle of the second write-pulse cycle.
        ram_addr_i = 32'h8000_0C00; ram_data_i = 32'hFFFF_0000; ram_be_n_i = 4'h0;
        ram_ce_n_i = 1'b0; ram_we_n_i = 1'b0; ram_oe_n_i = 1'b1;
        nWe = 0;
        for (int k = 0; k < 20 && nWe < 2; k++) begin
            @(negedge clk);
            if (!sram_we_n_o) nWe++;
        end
        checkOutput("t4_we_low_before_reset", 32'(nWe), 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("t4_we_n", 32'(sram_we_n_o), 32'd1);
        checkOutput("t4_data_oe", 32'(sram_data_oe), 32'd0);
        checkOutput("t4_stall", 32'(stall_from_bus), 32'd0);
        checkOutput("t4_ce_n", 32'(sram_ce_n_o), 32'd1);
        ram_ce_n_i = 1'b1; ram_we_n_i = 1'b1;
`ifdef FETCH_BUF_EN
        bufValid = 0;
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("t4_after_reset", 1, 0, 0, 32'h8000_0040, '0, '0, 4'hF);

`ifdef FETCH_BUF_EN
        applyStimulus("t5_fetch_a", 1, 0, 0, 32'h0000_0010, '0, '0, 4'hF);
        clearBus();
        applyStimulus("t5_fetch_hit", 1, 0, 0, 32'h0000_0010, '0, '0, 4'hF);
        checkOutput("t5_hit_ce_cycles", 32'(ceLowCycles), 32'd0);
        applyStimulus("t5_store", 0, 1, 1, '0, 32'h0000_0010, 32'hCAFE_F00D, 4'h0);
        clearBus();
        applyStimulus("t5_refetch", 1, 0, 0, 32'h0000_0010, '0, '0, 4'hF);
        checkOutput("t5_refetch_ce_cycles", 32'(ceLowCycles), 32'd2);
`endif

        for (int i = 0; i < 300; i++) begin
            int          kind, gap;
            logic [31:0] fa, da;
            kind = $urandom_range(0, 4);
            fa = {($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            da = {($urandom_range(0, 1) != 0) ? 4'h8 : 4'h0, 22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            case (kind)
                0: applyStimulus("rnd_fetch", 1, 0, 0, fa, da, $urandom, 4'($urandom));
                1: applyStimulus("rnd_load", 0, 1, 0, fa, da, $urandom, 4'($urandom));
                2: applyStimulus("rnd_store", 0, 1, 1, fa, da, $urandom, 4'($urandom));
                3: applyStimulus("rnd_fetch_load", 1, 1, 0, fa, da, $urandom, 4'($urandom));
                default: applyStimulus("rnd_fetch_store", 1, 1, 1, fa, da, $urandom, 4'($urandom));
            endcase
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end

        checkOutput("oe_we_overlap_cycles", 32'(bothLowCycles), 32'd0);
        checkOutput("scoreboard_leftover", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
